// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO in front of the line.
// Optional even-parity bit (8E1 frame) when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | start bit (low) for one bit time
// DATA   | eight data bits, LSB first
// PARITY | even-parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); pops the next byte on its last cycle if queued
//
// All three line outputs are registered from the current state, so the line
// trails the state register by exactly one cycle. TX_BUSY is derived the same
// way, which keeps it aligned with the frame actually visible on TX_OUT.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_WR,
  input  logic [7:0] TX_IN,
  output logic       TX_FULL,
  output logic       TX_OUT,
  output logic       TX_BUSY,
  output logic       TX_DONE
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          push, pop, fifo_empty;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          cnt_last;
  logic          tx_out_q, tx_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // A write while full is dropped even if a pop happens in the same cycle.
  assign push       = TX_WR & ~full_q;
  assign fifo_empty = (count_q == '0);
  assign cnt_last   = (cnt_q == CNT_LAST);

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= TX_IN;
  end

  // Next-state logic: bit timing, shifting and FIFO pops
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem_q[rd_ptr_q];
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_last) state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (cnt_last) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^mem_q[rd_ptr_q];
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered line outputs derived from the current state
  always_comb begin
    tx_out_d = 1'b1;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE:   busy_d   = 1'b0;
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_out_d = par_q;
`endif
      S_STOP:   done_d   = cnt_last;
      default:  busy_d   = 1'b0;
    endcase
  end

  // State, counters, FIFO control and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign TX_FULL = full_q;
  assign TX_OUT  = tx_out_q;
  assign TX_BUSY = busy_q;
  assign TX_DONE = done_q;

endmodule
